sigma_gpio_csr: RTL and testbench
=================================

SIGMA_GPIO_CSR -- requirements
Module: sigma_gpio_csr

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h80000000, bus base address; bits [4:0] are ignored.
REQ-002 SHALL have parameter GPIO_WIDTH, 32, number of GPIO pins per direction; legal range 1..32.
REQ-003 SHALL have parameter SYNC_STAGES, 2, input synchroniser depth; legal range 2..4.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-005 SHALL have port clk_i, input, 1, system clock.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port bus_req_i, input, 1, request valid.
REQ-008 SHALL have port bus_we_i, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port bus_addr_bi, input, 32, byte address.
REQ-010 SHALL have port bus_be_bi, input, 4, byte enables.
REQ-011 SHALL have port bus_wdata_bi, input, 32, write data.
REQ-012 SHALL have port bus_ack_o, output, 1, request accepted.
REQ-013 SHALL have port bus_resp_o, output, 1, read data valid.
REQ-014 SHALL have port bus_rdata_bo, output, 32, read data.
REQ-015 SHALL have port gpio_bi, input, GPIO_WIDTH, asynchronous pin inputs.
REQ-016 SHALL have port gpio_bo, output, GPIO_WIDTH, registered pin outputs.
REQ-017 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-018 bus_ack_o SHALL equal bus_req_i combinationally; a request is accepted in every cycle in which req=1, and back-to-back requests SHALL be supported.
REQ-019 A request is "hit" when addr[31:5]==BASE_ADDR[31:5]; register select SHALL be addr[4:2]. Offsets: 0x00 OUT (RW), 0x04 IN (RO), 0x08 SET (WO), 0x0C CLR (WO), 0x10 TGL (WO), 0x14 IRQ_EN (RW), 0x18 IRQ_EDGE (RW; 1=rising, 0=falling), 0x1C IRQ_PEND (R, write-1-to-clear).
REQ-020 Writes SHALL honour bus_be_bi per byte and SHALL NOT generate bus_resp_o.
REQ-021 OUT write SHALL load masked bytes; SET/CLR/TGL writes SHALL OR / AND-NOT / XOR the masked wdata into OUT in one cycle; reads of SET/CLR/TGL SHALL return 0.
REQ-022 Any accepted read, hit or miss, SHALL produce bus_resp_o=1 exactly one cycle later with registered rdata; misses and write-only registers SHALL return 0; bus_rdata_bo SHALL be 0 whenever bus_resp_o=0.
REQ-023 Bits [31:GPIO_WIDTH] of every register SHALL read 0, and writes to them SHALL be ignored.
REQ-024 gpio_bi SHALL pass through a SYNC_STAGES flip-flop chain; IN SHALL return the last synchroniser stage.
REQ-025 An edge on bit i SHALL be detected by comparing the synchronised value with a one-cycle-delayed copy, with polarity selected by IRQ_EDGE[i]; a detected edge SHALL set IRQ_PEND[i] regardless of IRQ_EN[i].
REQ-026 When an edge and a W1C of the same PEND bit occur in the same cycle, the set SHALL win.
REQ-027 irq_o SHALL be registered and equal |(IRQ_PEND & IRQ_EN), delayed by one cycle.
REQ-028 Edge detection SHALL be suppressed by a settle counter for SYNC_STAGES+1 cycles after rst_i deasserts, so that pins that are static-high at reset do not raise PEND.
REQ-029 Pin-to-PEND latency SHALL be SYNC_STAGES+1 cycles from the first clk_i edge that samples the new pin level.
REQ-030 gpio_bo SHALL be OUT directly, with no added latency: new OUT is visible in the cycle after the write is accepted.

Reset
REQ-031 While rst_i=1: OUT, IRQ_EN, IRQ_EDGE, IRQ_PEND, synchroniser, delayed copy, irq_o, bus_resp_o and bus_rdata_bo SHALL be 0; the settle counter SHALL be reloaded; requests SHALL have no effect.
REQ-032 A read accepted in the cycle before rst_i asserts SHALL NOT produce bus_resp_o.

Verification
REQ-033 Write OUT=0x0000_00F0 with be=4'b0001, then SET 0x0F, then TGL 0xFF -> gpio_bo = 0xF0, then 0xFF, then 0x00; readback 0x00 after a 1-cycle resp.
REQ-034 Read 0x8000_0020 (miss) -> resp=1 one cycle later with rdata=0; a write to the same address changes no register.
REQ-035 With IRQ_EDGE[3]=1 and IRQ_EN[3]=1, drive gpio_bi[3] 0->1 -> PEND=0x8 after 3 cycles and irq_o=1 one cycle later; W1C 0x8 -> irq_o=0.
REQ-036 Hold gpio_bi=0xFFFF_FFFF through reset -> PEND stays 0 after the settle period; a subsequent 1->0 edge with IRQ_EDGE=0 sets PEND.
REQ-037 An edge and a W1C of the same PEND bit in the same cycle -> PEND bit = 1; reads issued on consecutive cycles (OUT, IN, PEND) -> three consecutive resp pulses with the matching data.

Source files
------------

// File: rtl/sigma_gpio_csr.sv
// Memory-mapped GPIO block: byte-masked OUT with SET/CLR/TGL aliases, synchronised
// inputs, and per-pin edge interrupts with write-1-to-clear pending bits.
module sigma_gpio_csr #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          GPIO_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bus_req_i,
  input  logic                  bus_we_i,
  input  logic [31:0]           bus_addr_bi,
  input  logic [3:0]            bus_be_bi,
  input  logic [31:0]           bus_wdata_bi,
  output logic                  bus_ack_o,
  output logic                  bus_resp_o,
  output logic [31:0]           bus_rdata_bo,
  input  logic [GPIO_WIDTH-1:0] gpio_bi,
  output logic [GPIO_WIDTH-1:0] gpio_bo,
  output logic                  irq_o
);

  localparam logic [31:0] PIN_MASK    = (GPIO_WIDTH >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << GPIO_WIDTH) - 32'd1);
  localparam logic [2:0]  SETTLE_LOAD = 3'(SYNC_STAGES + 1);

  logic [31:0] out_reg, en_reg, edge_reg, pend_reg, prev_reg, rdata_reg;
  logic [31:0] out_next, en_next, edge_next, pend_next;
  logic [GPIO_WIDTH-1:0] sync_reg [SYNC_STAGES];
  logic [2:0]  settle_reg;
  logic        irq_reg, resp_reg;

  logic        hit, wr_hit, rd_acc, settle_done;
  logic [2:0]  sel;
  logic [31:0] be_mask, wmask, wval, w1c, sync_in, edge_det, rd_val;
  logic        unused_addr_bits;

  assign bus_ack_o        = bus_req_i;
  assign hit              = (bus_addr_bi[31:5] == BASE_ADDR[31:5]);
  assign sel              = bus_addr_bi[4:2];
  assign wr_hit           = bus_req_i & bus_we_i & hit;
  assign rd_acc           = bus_req_i & ~bus_we_i;
  assign unused_addr_bits = ^bus_addr_bi[1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_be
    assign be_mask[gi*8 +: 8] = {8{bus_be_bi[gi]}};
  end

  // Bits above GPIO_WIDTH are masked out of every write so they stay zero.
  assign wmask = be_mask & PIN_MASK;
  assign wval  = bus_wdata_bi & wmask;

  always_comb begin
    sync_in                   = '0;
    sync_in[GPIO_WIDTH-1:0]   = sync_reg[SYNC_STAGES-1];
  end

  assign settle_done = (settle_reg == 3'd0);
  assign edge_det    = settle_done
                       ? (((sync_in & ~prev_reg) & edge_reg) | ((~sync_in & prev_reg) & ~edge_reg))
                       : '0;

  always_comb begin
    out_next  = out_reg;
    en_next   = en_reg;
    edge_next = edge_reg;
    w1c       = '0;
    if (wr_hit) begin
      case (sel)
        3'd0: out_next  = (out_reg & ~wmask) | wval;
        3'd2: out_next  = out_reg | wval;
        3'd3: out_next  = out_reg & ~wval;
        3'd4: out_next  = out_reg ^ wval;
        3'd5: en_next   = (en_reg & ~wmask) | wval;
        3'd6: edge_next = (edge_reg & ~wmask) | wval;
        3'd7: w1c       = wval;
        default: ;
      endcase
    end
    // A fresh edge overrides a simultaneous clear of the same bit.
    pend_next = (pend_reg & ~w1c) | edge_det;
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (sel)
        3'd0: rd_val = out_reg;
        3'd1: rd_val = sync_in;
        3'd5: rd_val = en_reg;
        3'd6: rd_val = edge_reg;
        3'd7: rd_val = pend_reg;
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= gpio_bi;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_reg    <= '0;
      en_reg     <= '0;
      edge_reg   <= '0;
      pend_reg   <= '0;
      prev_reg   <= '0;
      settle_reg <= SETTLE_LOAD;
      irq_reg    <= 1'b0;
      resp_reg   <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      out_reg    <= out_next;
      en_reg     <= en_next;
      edge_reg   <= edge_next;
      pend_reg   <= pend_next;
      prev_reg   <= sync_in;
      if (!settle_done) settle_reg <= settle_reg - 3'd1;
      irq_reg    <= |(pend_reg & en_reg);
      resp_reg   <= rd_acc;
      rdata_reg  <= rd_acc ? rd_val : '0;
    end
  end

  // Gating with rst_i drops a response whose read was accepted just before reset.
  assign bus_resp_o   = resp_reg & ~rst_i;
  assign bus_rdata_bo = (resp_reg & ~rst_i) ? rdata_reg : '0;
  assign gpio_bo      = out_reg[GPIO_WIDTH-1:0];
  assign irq_o        = irq_reg;

endmodule

// File: tb/tb_sigma_gpio_csr.sv
// Self-checking bench for sigma_gpio_csr: directed scenarios plus randomized bus
// traffic checked against a register-level behavioural model.
module tb_sigma_gpio_csr;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int W = 32;
  localparam int S = 2;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        ack, resp, irq;
  logic [31:0] rdata;
  logic [W-1:0] gpio_in = '0, gpio_out;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_out, m_en, m_edge, m_pend, m_pin;

  always #5 clk = ~clk;

  sigma_gpio_csr #(.BASE_ADDR(BASE), .GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_i(rst), .bus_req_i(req), .bus_we_i(we), .bus_addr_bi(addr),
    .bus_be_bi(be), .bus_wdata_bi(wdata), .bus_ack_o(ack), .bus_resp_o(resp),
    .bus_rdata_bo(rdata), .gpio_bi(gpio_in), .gpio_bo(gpio_out), .irq_o(irq)
  );

  function automatic logic [31:0] ra(input logic [2:0] sel);
    return BASE | (32'(sel) << 2);
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] b);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (b[k]) m[k*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Register-level behaviour of a hit write.
  task automatic model_write(input logic [2:0] sel, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] bm, v;
    bm = byte_mask(b);
    v  = d & bm;
    case (sel)
      3'd0: m_out  = (m_out & ~bm) | v;
      3'd2: m_out  = m_out | v;
      3'd3: m_out  = m_out & ~v;
      3'd4: m_out  = m_out ^ v;
      3'd5: m_en   = (m_en & ~bm) | v;
      3'd6: m_edge = (m_edge & ~bm) | v;
      3'd7: m_pend = m_pend & ~v;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] sel);
    case (sel)
      3'd0: return m_out;
      3'd1: return m_pin;
      3'd5: return m_en;
      3'd6: return m_edge;
      3'd7: return m_pend;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic model_irq();
    return |(m_pend & m_en);
  endfunction

  // A settled pin change raises pending bits according to the chosen polarity.
  task automatic apply_pin_change(input logic [31:0] new_pins);
    m_pend = m_pend | (new_pins & ~m_pin & m_edge) | (~new_pins & m_pin & ~m_edge);
    m_pin  = new_pins;
  endtask

  task automatic model_reset();
    m_out = '0; m_en = '0; m_edge = '0; m_pend = '0; m_pin = gpio_in;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    req = 1'b1; we = 1'b1; addr = a; be = b; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    $display("wr addr=%h be=%b data=%h", a, b, d);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic r, output logic [31:0] d);
    req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    r = resp; d = rdata;
    $display("rd addr=%h resp=%b data=%h", a, r, d);
  endtask

  task automatic test_reset();
    logic r; logic [31:0] d;
    rst = 1'b1;
    tick(2);
    req = 1'b1; we = 1'b1; addr = ra(0); be = 4'hF; wdata = 32'hFFFF_FFFF;
    #1;
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_comb: got %b expected 1", ack); end
    tick(1);
    we = 1'b0;
    tick(1);
    req = 1'b0;
    n_checks++; if (gpio_out !== '0) begin n_fail++; $display("FAIL reset_gpio_out: got %h expected 0", gpio_out); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_checks++; if (resp !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL reset_resp: got resp=%b data=%h expected 0/0", resp, rdata); end
    rst = 1'b0;
    model_reset();
    tick(5);
    bus_read(ra(0), r, d);
    n_checks++; if (r !== 1'b1 || d !== model_read(0)) begin n_fail++; $display("FAIL reset_out_read: got resp=%b data=%h expected 1/%h", r, d, model_read(0)); end
    bus_read(ra(7), r, d);
    n_checks++; if (d !== model_read(7)) begin n_fail++; $display("FAIL reset_pend_read: got %h expected %h", d, model_read(7)); end
  endtask

  task automatic test_set_clr_tgl();
    logic r; logic [31:0] d;
    bus_write(ra(0), 4'b0001, 32'hAAAA_AAF0); model_write(0, 4'b0001, 32'hAAAA_AAF0);
    n_checks++; if (gpio_out !== m_out || m_out !== 32'hF0) begin n_fail++; $display("FAIL out_write: got %h expected %h", gpio_out, m_out); end
    bus_write(ra(2), 4'hF, 32'h0F); model_write(2, 4'hF, 32'h0F);
    n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL set_write: got %h expected %h", gpio_out, m_out); end
    bus_write(ra(4), 4'hF, 32'hFF); model_write(4, 4'hF, 32'hFF);
    n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL tgl_write: got %h expected %h", gpio_out, m_out); end
    bus_write(ra(0), 4'b1100, 32'h1234_5678); model_write(0, 4'b1100, 32'h1234_5678);
    bus_write(ra(3), 4'b1000, 32'hFF00_0000); model_write(3, 4'b1000, 32'hFF00_0000);
    n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL clr_write: got %h expected %h", gpio_out, m_out); end
    bus_read(ra(0), r, d);
    n_checks++; if (r !== 1'b1 || d !== m_out) begin n_fail++; $display("FAIL out_readback: got resp=%b data=%h expected 1/%h", r, d, m_out); end
    n_checks++; if (resp !== 1'b1) begin n_fail++; $display("FAIL resp_width: got %b expected 1", resp); end
    tick(1);
    n_checks++; if (resp !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL resp_single: got resp=%b data=%h expected 0/0", resp, rdata); end
    bus_read(ra(2), r, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL set_read_zero: got %h expected 0", d); end
  endtask

  task automatic test_miss();
    logic r; logic [31:0] d;
    bus_read(32'h8000_0020, r, d);
    n_checks++; if (r !== 1'b1 || d !== 32'h0) begin n_fail++; $display("FAIL miss_read: got resp=%b data=%h expected 1/0", r, d); end
    bus_write(32'h8000_0020, 4'hF, 32'hFFFF_FFFF);
    bus_write(32'h0000_0014, 4'hF, 32'hFFFF_FFFF);
    n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL miss_write_out: got %h expected %h", gpio_out, m_out); end
    bus_read(ra(5), r, d);
    n_checks++; if (d !== m_en) begin n_fail++; $display("FAIL miss_write_en: got %h expected %h", d, m_en); end
  endtask

  task automatic test_rise_irq();
    logic r; logic [31:0] d, pend_before;
    bus_write(ra(6), 4'hF, 32'h8); model_write(6, 4'hF, 32'h8);
    bus_write(ra(5), 4'hF, 32'h8); model_write(5, 4'hF, 32'h8);
    pend_before = m_pend;
    gpio_in[3] = 1'b1;
    tick(2);
    bus_read(ra(7), r, d);
    n_checks++; if (d !== pend_before) begin n_fail++; $display("FAIL pend_early: got %h expected %h", d, pend_before); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early: got %b expected 0", irq); end
    apply_pin_change(32'(gpio_in));
    bus_read(ra(7), r, d);
    n_checks++; if (d !== m_pend) begin n_fail++; $display("FAIL pend_rise: got %h expected %h", d, m_pend); end
    n_checks++; if (irq !== model_irq()) begin n_fail++; $display("FAIL irq_rise: got %b expected %b", irq, model_irq()); end
    bus_write(ra(7), 4'hF, 32'h8); model_write(7, 4'hF, 32'h8);
    tick(1);
    n_checks++; if (irq !== model_irq()) begin n_fail++; $display("FAIL irq_clear: got %b expected %b", irq, model_irq()); end
    gpio_in[3] = 1'b0; apply_pin_change(32'(gpio_in));
    tick(4);
  endtask

  task automatic test_settle();
    logic r; logic [31:0] d;
    gpio_in = '1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    model_reset();
    bus_write(ra(6), 4'hF, 32'hFFFF_FFFF); model_write(6, 4'hF, 32'hFFFF_FFFF);
    tick(6);
    bus_read(ra(7), r, d);
    n_checks++; if (d !== m_pend) begin n_fail++; $display("FAIL settle_pend: got %h expected %h", d, m_pend); end
    bus_write(ra(6), 4'hF, 32'h0); model_write(6, 4'hF, 32'h0);
    gpio_in[5] = 1'b0; apply_pin_change(32'(gpio_in));
    tick(4);
    bus_read(ra(7), r, d);
    n_checks++; if (d !== m_pend) begin n_fail++; $display("FAIL fall_pend: got %h expected %h", d, m_pend); end
    bus_read(ra(1), r, d);
    n_checks++; if (d !== m_pin) begin n_fail++; $display("FAIL in_read: got %h expected %h", d, m_pin); end
    gpio_in = '0; apply_pin_change(32'(gpio_in));
    tick(4);
    bus_write(ra(7), 4'hF, 32'hFFFF_FFFF); model_write(7, 4'hF, 32'hFFFF_FFFF);
  endtask

  task automatic test_race();
    logic r; logic [31:0] d;
    bus_write(ra(6), 4'hF, 32'h80); model_write(6, 4'hF, 32'h80);
    gpio_in[7] = 1'b1;
    tick(2);
    bus_write(ra(7), 4'hF, 32'h80); model_write(7, 4'hF, 32'h80);
    apply_pin_change(32'(gpio_in));
    bus_read(ra(7), r, d);
    n_checks++; if (d !== m_pend) begin n_fail++; $display("FAIL race_set_wins: got %h expected %h", d, m_pend); end
    bus_write(ra(7), 4'hF, 32'h80); model_write(7, 4'hF, 32'h80);
    bus_read(ra(7), r, d);
    n_checks++; if (d !== m_pend) begin n_fail++; $display("FAIL w1c_plain: got %h expected %h", d, m_pend); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] new_pins;
    new_pins = $urandom;
    gpio_in = new_pins; apply_pin_change(new_pins);
    tick(4);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = ra(0);
    @(posedge clk); #1; addr = ra(1);
    n_checks++; if (resp !== 1'b1 || rdata !== m_out) begin n_fail++; $display("FAIL b2b_out: got resp=%b data=%h expected 1/%h", resp, rdata, m_out); end
    @(posedge clk); #1; addr = ra(7);
    n_checks++; if (resp !== 1'b1 || rdata !== m_pin) begin n_fail++; $display("FAIL b2b_in: got resp=%b data=%h expected 1/%h", resp, rdata, m_pin); end
    @(posedge clk); #1; req = 1'b0;
    n_checks++; if (resp !== 1'b1 || rdata !== m_pend) begin n_fail++; $display("FAIL b2b_pend: got resp=%b data=%h expected 1/%h", resp, rdata, m_pend); end
    $display("rd b2b OUT/IN/PEND expected %h %h %h", m_out, m_pin, m_pend);
    tick(1);
    n_checks++; if (resp !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL b2b_idle: got resp=%b data=%h expected 0/0", resp, rdata); end
  endtask

  task automatic test_random();
    logic r, hit_sel, is_wr; logic [31:0] d, a, data, new_pins; logic [2:0] sel; logic [3:0] b;
    for (int i = 0; i < 80; i++) begin
      if (i % 16 == 0) begin
        new_pins = $urandom;
        gpio_in = new_pins; apply_pin_change(new_pins);
        tick(4);
      end
      sel     = 3'($urandom_range(0, 7));
      b       = 4'($urandom_range(0, 15));
      data    = $urandom;
      hit_sel = ($urandom_range(0, 4) != 0);
      is_wr   = $urandom_range(0, 1) == 1;
      a = hit_sel ? ra(sel) : (32'h8000_0020 + (32'($urandom_range(0, 7)) << 5) + (32'(sel) << 2));
      a[1:0] = 2'($urandom_range(0, 3));
      if (is_wr) begin
        bus_write(a, b, data);
        if (hit_sel) model_write(sel, b, data);
        n_checks++; if (gpio_out !== m_out) begin n_fail++; $display("FAIL rnd_gpio_out[%0d]: got %h expected %h", i, gpio_out, m_out); end
      end else begin
        bus_read(a, r, d);
        n_checks++; if (r !== 1'b1 || d !== (hit_sel ? model_read(sel) : 32'h0)) begin n_fail++; $display("FAIL rnd_read[%0d]: got resp=%b data=%h expected 1/%h", i, r, d, hit_sel ? model_read(sel) : 32'h0); end
        n_checks++; if (irq !== model_irq()) begin n_fail++; $display("FAIL rnd_irq[%0d]: got %b expected %b", i, irq, model_irq()); end
      end
    end
  endtask

  task automatic test_reset_read();
    bus_write(ra(0), 4'hF, 32'h5A5A_5A5A); model_write(0, 4'hF, 32'h5A5A_5A5A);
    req = 1'b1; we = 1'b0; addr = ra(0);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    #1;
    n_checks++; if (resp !== 1'b0 || rdata !== '0) begin n_fail++; $display("FAIL read_before_reset: got resp=%b data=%h expected 0/0", resp, rdata); end
    tick(1);
    n_checks++; if (resp !== 1'b0 || gpio_out !== '0) begin n_fail++; $display("FAIL reset_clears: got resp=%b out=%h expected 0/0", resp, gpio_out); end
    rst = 1'b0;
    model_reset();
    tick(5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_set_clr_tgl();
    test_miss();
    test_rise_irq();
    test_settle();
    test_race();
    test_back_to_back();
    test_random();
    test_reset_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
